// File: rtl/tl_ul_sram_slave.sv
// TileLink-UL slave: Get/PutFullData/PutPartialData into a byte-maskable word SRAM.
// Latency: one cycle from A accept to D valid, with all D fields registered.
// Backpressure: a_ready = !d_valid || d_ready; the single response register holds while d_ready is low.
module tl_ul_sram_slave #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 32,
    parameter int SOURCE_W = 5,
    parameter int SIZE_W   = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [2:0]            a_opcode,
    input  logic [2:0]            a_param,
    input  logic [SIZE_W-1:0]     a_size,
    input  logic [SOURCE_W-1:0]   a_source,
    input  logic [ADDR_W-1:0]     a_address,
    input  logic [DATA_W/8-1:0]   a_mask,
    input  logic [DATA_W-1:0]     a_data,
    output logic                  d_valid,
    input  logic                  d_ready,
    output logic [2:0]            d_opcode,
    output logic [SIZE_W-1:0]     d_size,
    output logic [SOURCE_W-1:0]   d_source,
    output logic                  d_denied,
    output logic [DATA_W-1:0]     d_data,
    output logic                  d_corrupt
);
    localparam int MASK_W = DATA_W / 8;
    localparam int DEPTH  = 2 ** (ADDR_W - 2);

    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_PUT_PART = 3'd1;
    localparam logic [2:0] OP_GET      = 3'd4;

    typedef struct packed {
        logic [2:0]          opcode;
        logic [SIZE_W-1:0]   size;
        logic [SOURCE_W-1:0] source;
        logic                denied;
        logic [DATA_W-1:0]   data;
        logic                corrupt;
    } d_rsp_t;

    logic [DATA_W-1:0] mem [DEPTH];

    d_rsp_t             rsp_q;
    d_rsp_t             rsp_nxt;
    logic               d_vld_q;
    logic               a_fire;
    logic [ADDR_W-3:0]  a_idx;
    logic [MASK_W-1:0]  lane_mask;
    logic               aligned;
    logic               mask_ok;
    logic               op_ok;
    logic               is_get;
    logic               is_put;
    logic               denied;

    assign a_ready = !d_vld_q || d_ready;
    assign a_fire  = a_valid && a_ready;
    assign a_idx   = a_address[ADDR_W-1:2];

    // Legality of the A beat; sizes above one word fall through to a full mask but are denied anyway.
    always_comb begin
        lane_mask = '1;
        aligned   = 1'b0;
        if (a_size == SIZE_W'(0)) begin
            lane_mask = MASK_W'(1) << a_address[1:0];
            aligned   = 1'b1;
        end else if (a_size == SIZE_W'(1)) begin
            lane_mask = MASK_W'(3) << a_address[1:0];
            aligned   = !a_address[0];
        end else if (a_size == SIZE_W'(2)) begin
            aligned   = (a_address[1:0] == 2'b00);
        end
        is_get  = (a_opcode == OP_GET);
        is_put  = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PART);
        op_ok   = is_get || is_put;
        mask_ok = (a_opcode == OP_PUT_PART) ? ((a_mask & ~lane_mask) == '0)
                                            : (a_mask == lane_mask);
        denied  = !(op_ok && (a_param == 3'd0) && (a_size <= SIZE_W'(2)) && aligned && mask_ok);
    end

    always_comb begin
        rsp_nxt         = '0;
        rsp_nxt.opcode  = is_get ? 3'd1 : 3'd0;
        rsp_nxt.size    = a_size;
        rsp_nxt.source  = a_source;
        rsp_nxt.denied  = denied;
        rsp_nxt.data    = (is_get && !denied) ? mem[a_idx] : '0;
        rsp_nxt.corrupt = is_get && denied;
    end

    // Writes land at the accept edge, so a Get accepted one cycle later already sees them.
    always_ff @(posedge clock) begin
        if (!reset && a_fire && is_put && !denied) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (a_mask[i]) begin
                    mem[a_idx][8*i +: 8] <= a_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            d_vld_q <= 1'b0;
            rsp_q   <= '0;
        end else if (a_fire) begin
            d_vld_q <= 1'b1;
            rsp_q   <= rsp_nxt;
        end else if (d_ready) begin
            d_vld_q <= 1'b0;
        end
    end

    assign d_valid   = d_vld_q;
    assign d_opcode  = rsp_q.opcode;
    assign d_size    = rsp_q.size;
    assign d_source  = rsp_q.source;
    assign d_denied  = rsp_q.denied;
    assign d_data    = rsp_q.data;
    assign d_corrupt = rsp_q.corrupt;
endmodule

// File: tb/tb_tl_ul_sram_slave.sv
// Directed bench for tl_ul_sram_slave: inputs change 1ns after posedge, outputs sampled on negedge.
module tb_tl_ul_sram_slave;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [2:0]  a_opcode = '0;
    logic [2:0]  a_param = '0;
    logic [2:0]  a_size = '0;
    logic [4:0]  a_source = '0;
    logic [13:0] a_address = '0;
    logic [3:0]  a_mask = '0;
    logic [31:0] a_data = '0;
    logic        d_valid;
    logic        d_ready = 1'b1;
    logic [2:0]  d_opcode;
    logic [2:0]  d_size;
    logic [4:0]  d_source;
    logic        d_denied;
    logic [31:0] d_data;
    logic        d_corrupt;

    int ntests = 0;
    int nfail  = 0;

    // {valid, opcode, size, source, denied, data, corrupt}
    logic [45:0] d_bus;
    assign d_bus = {d_valid, d_opcode, d_size, d_source, d_denied, d_data, d_corrupt};

    always #5 clock = ~clock;

    tl_ul_sram_slave dut (
        .clock     (clock),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_opcode  (a_opcode),
        .a_param   (a_param),
        .a_size    (a_size),
        .a_source  (a_source),
        .a_address (a_address),
        .a_mask    (a_mask),
        .a_data    (a_data),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_opcode  (d_opcode),
        .d_size    (d_size),
        .d_source  (d_source),
        .d_denied  (d_denied),
        .d_data    (d_data),
        .d_corrupt (d_corrupt)
    );

    task automatic drive_a(input logic [2:0] op, input logic [2:0] prm, input logic [2:0] sz,
                           input logic [4:0] src, input logic [13:0] addr,
                           input logic [3:0] msk, input logic [31:0] dat);
        a_valid   = 1'b1;
        a_opcode  = op;
        a_param   = prm;
        a_size    = sz;
        a_source  = src;
        a_address = addr;
        a_mask    = msk;
        a_data    = dat;
    endtask

    // One request presented for one cycle; the response is then visible at the following negedge.
    task automatic one_req(input logic [2:0] op, input logic [2:0] prm, input logic [2:0] sz,
                           input logic [4:0] src, input logic [13:0] addr,
                           input logic [3:0] msk, input logic [31:0] dat);
        @(posedge clock) #1;
        drive_a(op, prm, sz, src, addr, msk, dat);
        @(posedge clock) #1;
        a_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        ntests++;
        if (d_bus !== 46'd0) begin
            nfail++;
            $display("FAIL reset_d_outputs got %h want %h", d_bus, 46'd0);
        end
        ntests++;
        if (a_ready !== 1'b1) begin
            nfail++;
            $display("FAIL reset_a_ready got %b want 1", a_ready);
        end
        @(posedge clock) #1;
        reset = 1'b0;
    endtask

    task automatic test_put_get;
        one_req(3'd0, 3'd0, 3'd2, 5'd3, 14'h010, 4'hF, 32'hDEADBEEF);
        ntests++;
        if (d_bus !== {1'b1, 3'd0, 3'd2, 5'd3, 1'b0, 32'h0, 1'b0}) begin
            nfail++;
            $display("FAIL putfull_ack got %h want %h", d_bus, {1'b1, 3'd0, 3'd2, 5'd3, 1'b0, 32'h0, 1'b0});
        end
        one_req(3'd4, 3'd0, 3'd2, 5'd4, 14'h010, 4'hF, 32'h0);
        ntests++;
        if (d_bus !== {1'b1, 3'd1, 3'd2, 5'd4, 1'b0, 32'hDEADBEEF, 1'b0}) begin
            nfail++;
            $display("FAIL get_after_put got %h want %h", d_bus, {1'b1, 3'd1, 3'd2, 5'd4, 1'b0, 32'hDEADBEEF, 1'b0});
        end
        @(negedge clock);
        ntests++;
        if (d_valid !== 1'b0) begin
            nfail++;
            $display("FAIL d_valid_clears got %b want 0", d_valid);
        end
    endtask

    task automatic test_put_partial;
        one_req(3'd1, 3'd0, 3'd1, 5'd6, 14'h012, 4'hC, 32'h1234_0000);
        ntests++;
        if (d_bus !== {1'b1, 3'd0, 3'd1, 5'd6, 1'b0, 32'h0, 1'b0}) begin
            nfail++;
            $display("FAIL putpartial_ack got %h want %h", d_bus, {1'b1, 3'd0, 3'd1, 5'd6, 1'b0, 32'h0, 1'b0});
        end
        one_req(3'd4, 3'd0, 3'd2, 5'd7, 14'h010, 4'hF, 32'h0);
        ntests++;
        if (d_data !== 32'h1234BEEF) begin
            nfail++;
            $display("FAIL putpartial_merge got %h want %h", d_data, 32'h1234BEEF);
        end
    endtask

    task automatic test_back_to_back;
        @(posedge clock) #1;
        d_ready = 1'b0;
        drive_a(3'd4, 3'd0, 3'd2, 5'h1A, 14'h010, 4'hF, 32'h0);
        @(posedge clock) #1;
        drive_a(3'd0, 3'd0, 3'd2, 5'h07, 14'h020, 4'hF, 32'h0BADF00D);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            ntests++;
            if (d_bus !== {1'b1, 3'd1, 3'd2, 5'h1A, 1'b0, 32'h1234BEEF, 1'b0}) begin
                nfail++;
                $display("FAIL bp_hold cycle %0d got %h want %h", c, d_bus, {1'b1, 3'd1, 3'd2, 5'h1A, 1'b0, 32'h1234BEEF, 1'b0});
            end
            ntests++;
            if (a_ready !== 1'b0) begin
                nfail++;
                $display("FAIL bp_a_ready cycle %0d got %b want 0", c, a_ready);
            end
            @(posedge clock) #1;
        end
        d_ready = 1'b1;
        @(negedge clock);
        ntests++;
        if (a_ready !== 1'b1) begin
            nfail++;
            $display("FAIL bp_release_a_ready got %b want 1", a_ready);
        end
        @(posedge clock) #1;
        a_valid = 1'b0;
        @(negedge clock);
        ntests++;
        if (d_bus !== {1'b1, 3'd0, 3'd2, 5'h07, 1'b0, 32'h0, 1'b0}) begin
            nfail++;
            $display("FAIL b2b_no_bubble got %h want %h", d_bus, {1'b1, 3'd0, 3'd2, 5'h07, 1'b0, 32'h0, 1'b0});
        end
        one_req(3'd4, 3'd0, 3'd2, 5'd8, 14'h020, 4'hF, 32'h0);
        ntests++;
        if (d_data !== 32'h0BADF00D) begin
            nfail++;
            $display("FAIL b2b_put_written got %h want %h", d_data, 32'h0BADF00D);
        end
    endtask

    task automatic test_denials;
        one_req(3'd4, 3'd0, 3'd3, 5'd9, 14'h010, 4'hF, 32'h0);
        ntests++;
        if (d_bus !== {1'b1, 3'd1, 3'd3, 5'd9, 1'b1, 32'h0, 1'b1}) begin
            nfail++;
            $display("FAIL deny_get_size3 got %h want %h", d_bus, {1'b1, 3'd1, 3'd3, 5'd9, 1'b1, 32'h0, 1'b1});
        end
        one_req(3'd0, 3'd0, 3'd2, 5'd10, 14'h011, 4'hF, 32'hFFFFFFFF);
        ntests++;
        if (d_bus !== {1'b1, 3'd0, 3'd2, 5'd10, 1'b1, 32'h0, 1'b0}) begin
            nfail++;
            $display("FAIL deny_misaligned got %h want %h", d_bus, {1'b1, 3'd0, 3'd2, 5'd10, 1'b1, 32'h0, 1'b0});
        end
        one_req(3'd3, 3'd0, 3'd2, 5'd11, 14'h010, 4'hF, 32'hFFFFFFFF);
        ntests++;
        if (d_bus !== {1'b1, 3'd0, 3'd2, 5'd11, 1'b1, 32'h0, 1'b0}) begin
            nfail++;
            $display("FAIL deny_opcode3 got %h want %h", d_bus, {1'b1, 3'd0, 3'd2, 5'd11, 1'b1, 32'h0, 1'b0});
        end
        one_req(3'd0, 3'd1, 3'd2, 5'd12, 14'h010, 4'hF, 32'hFFFFFFFF);
        ntests++;
        if (d_denied !== 1'b1) begin
            nfail++;
            $display("FAIL deny_param got %b want 1", d_denied);
        end
        one_req(3'd1, 3'd0, 3'd0, 5'd13, 14'h010, 4'h3, 32'hFFFFFFFF);
        ntests++;
        if (d_denied !== 1'b1) begin
            nfail++;
            $display("FAIL deny_partial_mask got %b want 1", d_denied);
        end
        one_req(3'd0, 3'd0, 3'd2, 5'd14, 14'h010, 4'h7, 32'hFFFFFFFF);
        ntests++;
        if (d_denied !== 1'b1) begin
            nfail++;
            $display("FAIL deny_full_mask got %b want 1", d_denied);
        end
        one_req(3'd4, 3'd0, 3'd2, 5'd15, 14'h010, 4'hF, 32'h0);
        ntests++;
        if (d_bus !== {1'b1, 3'd1, 3'd2, 5'd15, 1'b0, 32'h1234BEEF, 1'b0}) begin
            nfail++;
            $display("FAIL deny_mem_unchanged got %h want %h", d_bus, {1'b1, 3'd1, 3'd2, 5'd15, 1'b0, 32'h1234BEEF, 1'b0});
        end
        one_req(3'd1, 3'd0, 3'd0, 5'd16, 14'h3FFF, 4'h8, 32'hAB00_0000);
        one_req(3'd4, 3'd0, 3'd0, 5'd17, 14'h3FFF, 4'h8, 32'h0);
        ntests++;
        if (d_denied !== 1'b0 || d_data[31:24] !== 8'hAB) begin
            nfail++;
            $display("FAIL top_byte got denied=%b byte=%h want denied=0 byte=ab", d_denied, d_data[31:24]);
        end
    endtask

    task automatic test_streaming;
        logic [31:0] wdat [16];
        for (int i = 0; i < 16; i++) begin
            wdat[i] = 32'hC0DE_0000 | (32'(i) << 8) | 32'(i);
        end
        for (int i = 0; i <= 16; i++) begin
            @(posedge clock) #1;
            if (i < 16) begin
                if (i % 2 == 0) begin
                    drive_a(3'd0, 3'd0, 3'd2, 5'(i), 14'h100 + 14'((i / 2) * 4), 4'hF, wdat[i]);
                end else begin
                    drive_a(3'd4, 3'd0, 3'd2, 5'(i), 14'h100 + 14'((i / 2) * 4), 4'hF, 32'h0);
                end
            end else begin
                a_valid = 1'b0;
            end
            @(negedge clock);
            if (i > 0) begin
                ntests++;
                if ((i - 1) % 2 == 0) begin
                    if (d_bus !== {1'b1, 3'd0, 3'd2, 5'(i - 1), 1'b0, 32'h0, 1'b0}) begin
                        nfail++;
                        $display("FAIL stream_put %0d got %h want %h", i - 1, d_bus, {1'b1, 3'd0, 3'd2, 5'(i - 1), 1'b0, 32'h0, 1'b0});
                    end
                end else begin
                    if (d_bus !== {1'b1, 3'd1, 3'd2, 5'(i - 1), 1'b0, wdat[i - 2], 1'b0}) begin
                        nfail++;
                        $display("FAIL stream_get %0d got %h want %h", i - 1, d_bus, {1'b1, 3'd1, 3'd2, 5'(i - 1), 1'b0, wdat[i - 2], 1'b0});
                    end
                end
            end
        end
        @(negedge clock);
        ntests++;
        if (d_valid !== 1'b0) begin
            nfail++;
            $display("FAIL stream_drain got %b want 0", d_valid);
        end
    endtask

    task automatic test_reset_mid;
        @(posedge clock) #1;
        d_ready = 1'b0;
        drive_a(3'd4, 3'd0, 3'd2, 5'h15, 14'h010, 4'hF, 32'h0);
        @(posedge clock) #1;
        a_valid = 1'b0;
        @(negedge clock);
        ntests++;
        if (d_valid !== 1'b1) begin
            nfail++;
            $display("FAIL rst_mid_pending got %b want 1", d_valid);
        end
        @(posedge clock) #1;
        reset = 1'b1;
        @(posedge clock) #1;
        ntests++;
        if (d_bus !== 46'd0) begin
            nfail++;
            $display("FAIL rst_mid_cleared got %h want %h", d_bus, 46'd0);
        end
        reset = 1'b0;
        @(negedge clock);
        ntests++;
        if (a_ready !== 1'b1 || d_valid !== 1'b0) begin
            nfail++;
            $display("FAIL rst_mid_release got a_ready=%b d_valid=%b want 1 0", a_ready, d_valid);
        end
        d_ready = 1'b1;
    endtask

    initial begin
        test_reset;
        test_put_get;
        test_put_partial;
        test_back_to_back;
        test_denials;
        test_streaming;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/tl_ul_sram_slave.md
Name: tl_ul_sram_slave

Overview:
- TileLink-UL slave terminating the A/D link that the protocol monitor checks.
- Sits directly downstream of that link. Consumes A-channel Get/PutFullData/PutPartialData and returns AccessAck/AccessAckData on D.
- Backed by an internal word-wide byte-maskable memory.
- Single-entry response buffer gives full throughput when d_ready is held high.

Parameters:
- ADDR_W, 14, A-channel address width in bytes; memory depth = 2^(ADDR_W-2) words.
- DATA_W, 32, data width; only 32 is supported (mask width 4).
- SOURCE_W, 5, source ID width.
- SIZE_W, 3, size field width (log2 bytes).

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- a_valid  in  1  A request valid
- a_ready  out  1  A request accepted when high with a_valid
- a_opcode  in  3  0=PutFullData, 1=PutPartialData, 4=Get
- a_param  in  3  must be 0
- a_size  in  SIZE_W  log2 transfer bytes
- a_source  in  SOURCE_W  requester ID
- a_address  in  ADDR_W  byte address
- a_mask  in  4  byte lanes
- a_data  in  32  write data
- d_valid  out  1  response valid
- d_ready  in  1  response accepted
- d_opcode  out  3  0=AccessAck, 1=AccessAckData
- d_size  out  SIZE_W  echo of a_size
- d_source  out  SOURCE_W  echo of a_source
- d_denied  out  1  request rejected
- d_data  out  32  read data; 0 when not AccessAckData or when denied
- d_corrupt  out  1  equals d_denied on AccessAckData, else 0

Behaviour:
- Reset: d_valid=0; d_opcode, d_size, d_source, d_denied, d_data, d_corrupt = 0. Any pending response is dropped. Memory contents are not reset.
- a_ready = !d_valid || d_ready (combinational). a_fire = a_valid && a_ready.
- Latency: a_fire in cycle N gives d_valid=1 in cycle N+1 with all D fields registered.
- D fields hold stable while d_valid && !d_ready.
- d_valid clears after d_fire unless a new a_fire occurs in the same cycle. The back-to-back case of d_fire and a_fire together loads the new response with no bubble.
- Denial check is evaluated at a_fire. A request is denied if any of these holds:
  - opcode not in {0,1,4};
  - a_param != 0;
  - a_size > 2;
  - address not aligned to 2^a_size;
  - mask not exactly the lane mask implied by size and address[1:0] (Get, PutFull);
  - PutPartial mask has bits outside that lane mask.
- A denied request performs no memory access.
- Opcode mapping:
  - Get gives d_opcode=1.
  - Put* gives d_opcode=0.
  - An illegal opcode gives d_opcode=0 with d_denied=1.
- Writes: at a_fire of a non-denied Put, the word at address[ADDR_W-1:2] is updated on lanes where a_mask=1 using a_data lanes.
- Reads: a non-denied Get registers the full word at a_fire. All 4 lanes are returned unmasked.
- Ordering: a Get accepted the cycle after a Put to the same word returns the new data. Same-cycle accept of two requests is impossible (one request per cycle).
- Reset asserted mid-response: d_valid=0 on the next edge; a_ready=1 in the cycle following reset deassertion.
- Throughput: 1 request/cycle with d_ready=1.
- No internal state besides the response register, the d_valid flag and the memory. No FSM beyond the implicit IDLE (d_valid=0) / RESP (d_valid=1) states:
  - IDLE to RESP on a_fire.
  - RESP to IDLE on d_fire without a_fire.
  - RESP stays RESP on d_fire with a_fire.

Test Plan:
- Put then Get: PutFull addr 0x010, size 2, mask 0xF, data 0xDEADBEEF, then Get addr 0x010 size 2 mask 0xF.
  -> responses AccessAck (d_opcode=0, d_denied=0) then AccessAckData with d_data=0xDEADBEEF, each one cycle after accept, source echoed.
- PutPartial: addr 0x012 size 1 mask 0xC data 0x1234_0000 over 0xDEADBEEF, then Get word 0x010.
  -> d_data=0x1234BEEF.
- Backpressure: d_ready=0 for 3 cycles after a Get from source 5'h1A.
  -> a_ready=0 while held, D fields stable; d_ready=1 with a new a_valid gives a back-to-back response, no bubble.
- Denials, each expected -> d_denied=1, memory unchanged:
  - Get size 3 -> d_corrupt=1, d_data=0.
  - PutFull addr 0x011 size 2 -> d_opcode=0.
  - opcode 3 -> d_opcode=0.
- Streaming: 16 alternating Put/Get to distinct words with d_ready=1.
  -> 16 responses in 16 consecutive cycles, each Get returning its preceding Put's data.
- Reset mid-operation: reset asserted while d_valid=1 and d_ready=0.
  -> d_valid=0 next cycle, all D outputs 0, a_ready=1 after release.
